i2c_arbiter: RTL and testbench

I2C_ARBITER -- requirements
Module: i2c_arbiter

---
 rtl/i2c_arb_if.sv | 35 +++
 rtl/i2c_arbiter.sv | 146 ++++++++++++++
 tb/tb_i2c_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_arb_if.sv
// Requester, response and I2C-master command bundle for i2c_arbiter.
// slave = arbiter side, master = requesters plus I2C master side.
interface i2c_arb_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [7*NREQ-1:0] req_addr;
    logic [8*NREQ-1:0] req_wdata;
    logic [NREQ-1:0]   req_rw;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic [7:0]        rsp_rdata;
    logic              rsp_err;
    logic [6:0]        m_addr;
    logic [7:0]        m_data_in;
    logic              m_rw;
    logic              m_enable;
    logic              m_done;
    logic [7:0]        m_data_out;
    logic              busy;

    modport slave (
        input  req, req_addr, req_wdata, req_rw,
        input  m_done, m_data_out,
        output gnt, rsp_valid, rsp_rdata, rsp_err,
        output m_addr, m_data_in, m_rw, m_enable, busy
    );

    modport master (
        output req, req_addr, req_wdata, req_rw,
        output m_done, m_data_out,
        input  gnt, rsp_valid, rsp_rdata, rsp_err,
        input  m_addr, m_data_in, m_rw, m_enable, busy
    );
endinterface

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C master among NREQ requesters.
// Define I2C_ARB_TIMEOUT_EN to build the WAIT watchdog (TO_CYCLES).
module i2c_arbiter #(
    parameter int NREQ      = 4,
    parameter int TO_CYCLES = 4096
) (
    input  logic     clk,
    input  logic     rst,
    i2c_arb_if.slave bus
);
    localparam int W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]   state;
    logic [W-1:0] last_winner;
    logic [W-1:0] winner;
    logic [W-1:0] pick;
    logic         found;
    logic         done_armed;
    logic         qual_done;
    logic         to_hit;
    logic [6:0]   sel_addr;
    logic [7:0]   sel_wdata;
    logic         sel_rw;

    // Search starts one past the last served requester.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && bus.req[W'((int'(last_winner) + k) % NREQ)]) begin
                found = 1'b1;
                pick  = W'((int'(last_winner) + k) % NREQ);
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_rw    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick == W'(i)) begin
                sel_addr  = bus.req_addr[7*i +: 7];
                sel_wdata = bus.req_wdata[8*i +: 8];
                sel_rw    = bus.req_rw[i];
            end
        end
    end

    // A done-high only counts once it has been seen low in this WAIT.
    assign qual_done = bus.m_done && done_armed;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYCLES + 1);

    logic [CW-1:0] to_cnt;
    logic          err_q;

    assign to_hit      = (to_cnt == CW'(TO_CYCLES - 1));
    assign bus.rsp_err = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == S_ISSUE) begin
                to_cnt <= '0;
            end else if (state == S_WAIT) begin
                to_cnt <= to_cnt + CW'(1);
            end
            if (state == S_WAIT && (qual_done || to_hit)) begin
                err_q <= !qual_done;
            end
        end
    end
`else
    // Constant zero; the watchdog is not built.
    assign to_hit      = (TO_CYCLES < 0);
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            bus.gnt       <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_rdata <= '0;
            bus.m_addr    <= '0;
            bus.m_data_in <= '0;
            bus.m_rw      <= 1'b0;
            bus.m_enable  <= 1'b0;
            bus.busy      <= 1'b0;
            last_winner   <= W'(NREQ - 1);
            winner        <= '0;
            done_armed    <= 1'b0;
        end else begin
            bus.gnt       <= '0;
            bus.rsp_valid <= '0;
            bus.m_enable  <= 1'b0;
            unique case (1'b1)
                (state == S_IDLE): begin
                    if (found) begin
                        winner        <= pick;
                        bus.m_addr    <= sel_addr;
                        bus.m_data_in <= sel_wdata;
                        bus.m_rw      <= sel_rw;
                        bus.gnt       <= ONE << pick;
                        bus.busy      <= 1'b1;
                        state         <= S_ISSUE;
                    end
                end
                (state == S_ISSUE): begin
                    bus.m_enable <= 1'b1;
                    done_armed   <= 1'b0;
                    state        <= S_WAIT;
                end
                (state == S_WAIT): begin
                    if (!bus.m_done) begin
                        done_armed <= 1'b1;
                    end
                    if (qual_done || to_hit) begin
                        bus.rsp_valid <= ONE << winner;
                        bus.rsp_rdata <= (qual_done && bus.m_rw) ?
                                         bus.m_data_out : 8'h00;
                        state         <= S_RESP;
                    end
                end
                (state == S_RESP): begin
                    last_winner <= winner;
                    bus.busy    <= 1'b0;
                    state       <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed vector bench for i2c_arbiter (NREQ=4, TO_CYCLES=16).
module tb_i2c_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    i2c_arb_if #(.NREQ(4)) bus ();

    i2c_arbiter #(.NREQ(4), .TO_CYCLES(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        int         idx;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic       rw;
        logic [7:0] dout;
        logic [3:0] e_gnt;
        logic [7:0] e_rdata;
    } vec_t;

    vec_t vt [4];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        int n;
        @(negedge clk);
        n = int'(|bus.gnt) + int'(|bus.rsp_valid) + int'(bus.m_enable);
        chk("excl", 32'(n > 1), 32'(0));
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_gnt"}, 32'(bus.gnt), 32'(0));
        chk({nm, "_rsp"}, 32'(bus.rsp_valid), 32'(0));
        chk({nm, "_rdata"}, 32'(bus.rsp_rdata), 32'(0));
        chk({nm, "_err"}, 32'(bus.rsp_err), 32'(0));
        chk({nm, "_addr"}, 32'(bus.m_addr), 32'(0));
        chk({nm, "_wd"}, 32'(bus.m_data_in), 32'(0));
        chk({nm, "_rw"}, 32'(bus.m_rw), 32'(0));
        chk({nm, "_en"}, 32'(bus.m_enable), 32'(0));
        chk({nm, "_busy"}, 32'(bus.busy), 32'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (bus.gnt != 4'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic serve_fair(input logic [3:0] exp);
        bit ok;
        wait_gnt(ok);
        chk("fair_wait", 32'(ok), 32'(1));
        chk("fair_gnt", 32'(bus.gnt), 32'(exp));
        tick();
        chk("fair_en", 32'(bus.m_enable), 32'(1));
        chk("fair_busy", 32'(bus.busy), 32'(1));
        bus.m_done = 1'b0;
        tick();
        chk("fair_nognt", 32'(bus.gnt), 32'(0));
        bus.m_done = 1'b1;
        tick();
        chk("fair_rsp", 32'(bus.rsp_valid), 32'(exp));
        bus.m_done = 1'b0;
        tick();
        chk("fair_idle", 32'(bus.busy), 32'(0));
    endtask

    initial begin
        int hits;
        vt[0] = '{1, 7'h55, 8'hA5, 1'b0, 8'h3C, 4'b0010, 8'h00};
        vt[1] = '{2, 7'h12, 8'h00, 1'b1, 8'h5A, 4'b0100, 8'h5A};
        vt[2] = '{0, 7'h7F, 8'hFF, 1'b1, 8'hC3, 4'b0001, 8'hC3};
        vt[3] = '{3, 7'h00, 8'h81, 1'b0, 8'hFF, 4'b1000, 8'h00};

        bus.req        = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_rw     = '0;
        bus.m_done     = 1'b0;
        bus.m_data_out = '0;

        do_reset();
        chk_zero("rst");
        for (int c = 0; c < 3; c++) tick();
        chk("idle_busy", 32'(bus.busy), 32'(0));
        chk("idle_gnt", 32'(bus.gnt), 32'(0));

        for (int v = 0; v < 4; v++) begin
            bus.req                   = 4'(1 << vt[v].idx);
            bus.req_addr[7*vt[v].idx +: 7]  = vt[v].addr;
            bus.req_wdata[8*vt[v].idx +: 8] = vt[v].wdata;
            bus.req_rw[vt[v].idx]     = vt[v].rw;
            bus.m_done                = 1'b0;
            tick();
            chk("v_gnt", 32'(bus.gnt), 32'(vt[v].e_gnt));
            chk("v_busy", 32'(bus.busy), 32'(1));
            chk("v_en0", 32'(bus.m_enable), 32'(0));
            bus.req       = '0;
            bus.req_addr  = ~bus.req_addr;
            bus.req_wdata = ~bus.req_wdata;
            bus.req_rw    = ~bus.req_rw;
            tick();
            chk("v_en", 32'(bus.m_enable), 32'(1));
            chk("v_addr", 32'(bus.m_addr), 32'(vt[v].addr));
            chk("v_wd", 32'(bus.m_data_in), 32'(vt[v].wdata));
            chk("v_rw", 32'(bus.m_rw), 32'(vt[v].rw));
            tick();
            chk("v_en1", 32'(bus.m_enable), 32'(0));
            chk("v_rsp0", 32'(bus.rsp_valid), 32'(0));
            bus.m_done     = 1'b1;
            bus.m_data_out = vt[v].dout;
            tick();
            chk("v_rsp", 32'(bus.rsp_valid), 32'(vt[v].e_gnt));
            chk("v_rdata", 32'(bus.rsp_rdata), 32'(vt[v].e_rdata));
            chk("v_err", 32'(bus.rsp_err), 32'(0));
            bus.m_done = 1'b0;
            tick();
            chk("v_rsp1", 32'(bus.rsp_valid), 32'(0));
            chk("v_idle", 32'(bus.busy), 32'(0));
        end

        rst      = 1'b1;
        bus.req  = 4'hF;
        do_reset();
        serve_fair(4'b0001);
        serve_fair(4'b0010);
        serve_fair(4'b0100);
        serve_fair(4'b1000);
        serve_fair(4'b0001);
        bus.req = '0;
        tick();
        tick();

        bus.m_done = 1'b1;
        bus.req    = 4'b0001;
        tick();
        chk("st_gnt", 32'(bus.gnt), 32'(1));
        bus.req = '0;
        tick();
        chk("st_en", 32'(bus.m_enable), 32'(1));
        tick();
        chk("st_rsp_a", 32'(bus.rsp_valid), 32'(0));
        tick();
        chk("st_rsp_b", 32'(bus.rsp_valid), 32'(0));
        bus.m_done = 1'b0;
        tick();
        chk("st_rsp_c", 32'(bus.rsp_valid), 32'(0));
        bus.m_done = 1'b1;
        tick();
        chk("st_rsp", 32'(bus.rsp_valid), 32'(1));
        bus.m_done = 1'b0;
        tick();

        bus.req = 4'b0100;
        tick();
        chk("rm_gnt", 32'(bus.gnt), 32'(4'b0100));
        bus.req = '0;
        tick();
        tick();
        chk("rm_busy", 32'(bus.busy), 32'(1));
        rst = 1'b1;
        tick();
        chk_zero("rm");
        rst        = 1'b0;
        bus.m_done = 1'b1;
        hits       = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus.rsp_valid != 4'b0) hits++;
        end
        chk("rm_norsp", 32'(hits), 32'(0));
        bus.m_done = 1'b0;
        bus.req    = 4'b0101;
        tick();
        chk("rm_gnt0", 32'(bus.gnt), 32'(4'b0001));
        bus.req = '0;
        tick();
        tick();
        bus.m_done = 1'b1;
        tick();
        chk("rm_rsp0", 32'(bus.rsp_valid), 32'(4'b0001));
        bus.m_done = 1'b0;

        do_reset();
        bus.m_data_out = 8'hEE;
        bus.req_rw     = 4'hF;
        bus.req        = 4'b1000;
        tick();
        chk("to_gnt", 32'(bus.gnt), 32'(4'b1000));
        bus.req = '0;
        tick();
        chk("to_en", 32'(bus.m_enable), 32'(1));
`ifdef I2C_ARB_TIMEOUT_EN
        hits = 0;
        for (int k = 1; k < 16; k++) begin
            tick();
            if (bus.rsp_valid != 4'b0) hits++;
        end
        chk("to_early", 32'(hits), 32'(0));
        tick();
        chk("to_rsp", 32'(bus.rsp_valid), 32'(4'b1000));
        chk("to_err", 32'(bus.rsp_err), 32'(1));
        chk("to_rdata", 32'(bus.rsp_rdata), 32'(0));
        tick();
        chk("to_idle", 32'(bus.busy), 32'(0));
`else
        hits = 0;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (bus.rsp_valid != 4'b0) hits++;
        end
        chk("to_none", 32'(hits), 32'(0));
        chk("to_busy", 32'(bus.busy), 32'(1));
        chk("to_err", 32'(bus.rsp_err), 32'(0));
`endif
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
